noise_wr_ctrl: RTL and testbench
================================

Name: noise_wr_ctrl

Overview:
- Writer side of the noise sample buffer: captures a programmed number of ADC noise samples into the 4096-word noise RAM.
- The free-running 12-bit read address counter later reads that RAM out.
- Sits between the ADC sample interface and the write port of the dual-port noise RAM.
- Armed by the acquisition sequencer with a one-cycle start pulse; reports busy/done back to it.

Parameters:
- AW, 12, RAM address width; buffer depth is 2^AW words.
- DW, 16, sample/RAM data width.
- SW, 8, width of the skip (discard) count.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse; arms a capture.
- abort  input  1  one-cycle pulse; cancels the capture in progress.
- skip_num  input  SW  samples to discard after start; sampled on start.
- wr_len  input  AW  samples to store; 0 means 2^AW; sampled on start.
- sample_valid  input  1  one-cycle strobe per ADC sample.
- sample_data  input  DW  ADC sample, valid with sample_valid.
- ram_we  output  1  RAM write enable, one cycle per stored sample.
- ram_addr  output  AW  RAM write address.
- ram_data  output  DW  RAM write data.
- busy  output  1  high from the cycle after an accepted start until DONE or IDLE.
- done  output  1  level; capture complete, held until the next accepted start.
- wr_count  output  AW+1  samples stored in the current/last capture.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - ram_we=0, ram_addr=0, ram_data=0, busy=0, done=0, wr_count=0.
  - Latched skip/len registers are cleared.
- States: IDLE, SKIP, WRITE, DONE.
- IDLE:
  - start=1 -> latch skip_num and len; len = wr_len, or 2^AW if wr_len=0.
  - Clear wr_count, ram_addr and done.
  - Go to SKIP if skip_num != 0, else WRITE.
- SKIP:
  - Each sample_valid decrements the skip counter; the sample is not written.
  - When the counter reaches 0 on a strobe, go to WRITE the next cycle.
  - A strobe in the same cycle as the transition to WRITE is discarded.
- WRITE:
  - sample_valid=1 -> next cycle ram_we=1, ram_data=sample_data, ram_addr=current write address.
  - Write address then increments; wr_count increments.
  - Fixed write latency: 1 clock from strobe to ram_we.
  - Back-to-back strobes on every cycle are supported, giving ram_we high for consecutive cycles with consecutive addresses.
  - On the strobe that brings wr_count to len, go to DONE. That last write still issues.
- DONE:
  - done=1, busy=0.
  - Remains until start, which behaves as in IDLE.
  - ram_addr holds the last written address.
- busy = 1 in SKIP and WRITE, else 0.
- Address arithmetic: modulo 2^AW.
  - With len=2^AW the last address is 2^AW-1; the address wraps to 0 only internally and is never written again.
  - wr_count reaches 2^AW, which needs the extra bit.
- start while busy: ignored. The capture continues and the parameters are not re-latched.
- abort in SKIP or WRITE:
  - Go to IDLE next cycle, busy=0, done stays 0.
  - wr_count keeps the partial count.
  - A write already registered for that cycle completes; no further writes.
- abort in IDLE or DONE: no effect.
- abort and start in the same cycle in IDLE/DONE: start wins.
- sample_valid in IDLE or DONE: ignored; ram_we stays 0.
- rst_n asserted mid-capture: immediate return to reset values, including ram_we=0 asynchronously.
- ram_we is never high outside the cycle after an accepted WRITE-state strobe.

Test Plan:
1. Basic capture:
   - Stimulus: reset, then start with skip_num=0, wr_len=4, then 4 strobes with data 0x1111, 0x2222, 0x3333, 0x4444.
   - Response: ram_we pulses at addresses 0..3 with matching data, each 1 cycle after its strobe; done=1, busy=0, wr_count=4.
2. Skip:
   - Stimulus: skip_num=3, wr_len=2, then 5 strobes with data 1..5.
   - Response: only data 4 and 5 are written, at addresses 0 and 1; wr_count=2.
3. Full buffer, back-to-back:
   - Stimulus: wr_len=0, sample_valid held high for 4100 cycles with incrementing data.
   - Response: 4096 writes at addresses 0..4095 with no gaps; done after the last one; wr_count=4096; the 4 extra strobes produce no ram_we.
4. Abort and re-arm:
   - Stimulus: wr_len=10, abort after 6 writes, then start again with wr_len=2.
   - Response: busy drops and done stays 0 after the abort, with wr_count=6; the new capture writes addresses 0 and 1 and completes with done=1.
5. Start ignored while busy:
   - Stimulus: start with wr_len=3; assert start again with wr_len=8 after 1 write.
   - Response: capture ends after exactly 3 writes.
6. Async reset mid-WRITE:
   - Stimulus: drop rst_n between clock edges.
   - Response: ram_we, busy and done are 0 immediately; after release, strobes produce no writes until the next start.

Source files
------------

// File: rtl/noise_wr_ctrl.sv
// Noise sample buffer writer: skips, then stores a programmed
// number of ADC samples into the noise RAM write port.
module noise_wr_ctrl #(
    parameter int AW = 12,
    parameter int DW = 16,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [SW-1:0] skip_num,
    input  logic [AW-1:0] wr_len,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   wr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_WRITE,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] skip_cnt_q, skip_cnt_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   wr_count_q, wr_count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_data_q, ram_data_d;
    logic          ram_we_q, ram_we_d;

    logic          start_ok;
    logic          skip_go;
    logic          wr_go;
    logic          last_wr;
    logic [AW:0]   wr_count_inc;

    // Strobe qualifiers: abort suppresses any strobe in the same cycle
    always_comb begin
        start_ok     = start &&
                       (state_q == S_IDLE || state_q == S_DONE);
        skip_go      = (state_q == S_SKIP) && !abort && sample_valid;
        wr_go        = (state_q == S_WRITE) && !abort && sample_valid;
        wr_count_inc = wr_count_q + 1'b1;
        last_wr      = wr_go && (wr_count_inc == len_q);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            skip_cnt_q <= '0;
            len_q      <= '0;
            wr_count_q <= '0;
            wr_ptr_q   <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            len_q      <= len_d;
            wr_count_q <= wr_count_d;
            wr_ptr_q   <= wr_ptr_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
        end
    end

    // Next-state: start wins over abort when not capturing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok)
                    state_d = (skip_num != '0) ? S_SKIP : S_WRITE;
            end
            S_SKIP: begin
                if (abort)
                    state_d = S_IDLE;
                else if (skip_go && skip_cnt_q == SW'(1))
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                if (abort)
                    state_d = S_IDLE;
                else if (last_wr)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: latch parameters on start, register one write per strobe
    always_comb begin
        skip_cnt_d = skip_cnt_q;
        len_d      = len_q;
        wr_count_d = wr_count_q;
        wr_ptr_d   = wr_ptr_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        if (start_ok) begin
            skip_cnt_d = skip_num;
            len_d      = (wr_len == '0) ? {1'b1, {AW{1'b0}}}
                                        : {1'b0, wr_len};
            wr_count_d = '0;
            wr_ptr_d   = '0;
            ram_addr_d = '0;
        end else if (skip_go) begin
            skip_cnt_d = skip_cnt_q - 1'b1;
        end else if (wr_go) begin
            ram_we_d   = 1'b1;
            ram_addr_d = wr_ptr_q;
            ram_data_d = sample_data;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            wr_count_d = wr_count_inc;
        end
    end

    // Outputs: status decoded from state, write port from registers
    always_comb begin
        busy     = (state_q == S_SKIP) || (state_q == S_WRITE);
        done     = (state_q == S_DONE);
        ram_we   = ram_we_q;
        ram_addr = ram_addr_q;
        ram_data = ram_data_q;
        wr_count = wr_count_q;
    end

endmodule

// File: tb/tb_noise_wr_ctrl.sv
// Directed self-checking bench for noise_wr_ctrl.
// Inputs change 1ns after the rising edge; outputs checked there too.
module tb_noise_wr_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  skip_num;
    logic [11:0] wr_len;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [15:0] ram_data;
    logic        busy;
    logic        done;
    logic [12:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    noise_wr_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .skip_num     (skip_num),
        .wr_len       (wr_len),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .busy         (busy),
        .done         (done),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [7:0] sk, input logic [11:0] ln);
        start    = 1'b1;
        skip_num = sk;
        wr_len   = ln;
        tick();
        start    = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    initial begin
        int bad;
        int nwr;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        skip_num = '0;
        wr_len = '0;
        sample_valid = 1'b0;
        sample_data = '0;
        tick();
        tick();
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", wr_count, 0);
        rst_n = 1'b1;
        tick();
        strobe(16'hdead);
        chk("idle_strobe_we", ram_we, 0);

        // 1: basic capture, with a gap between strobes
        arm(8'd0, 12'd4);
        chk("t1_busy", busy, 1);
        chk("t1_we0", ram_we, 0);
        strobe(16'h1111);
        chk("t1_we_a", ram_we, 1);
        chk("t1_addr_a", ram_addr, 0);
        chk("t1_data_a", ram_data, 16'h1111);
        tick();
        chk("t1_gap_we", ram_we, 0);
        strobe(16'h2222);
        chk("t1_addr_b", ram_addr, 1);
        chk("t1_data_b", ram_data, 16'h2222);
        strobe(16'h3333);
        chk("t1_addr_c", ram_addr, 2);
        chk("t1_data_c", ram_data, 16'h3333);
        chk("t1_busy_c", busy, 1);
        strobe(16'h4444);
        chk("t1_we_d", ram_we, 1);
        chk("t1_addr_d", ram_addr, 3);
        chk("t1_data_d", ram_data, 16'h4444);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_cnt", wr_count, 4);
        strobe(16'h5555);
        chk("t1_done_strobe_we", ram_we, 0);
        chk("t1_done_addr", ram_addr, 3);

        // 2: skip three samples
        arm(8'd3, 12'd2);
        chk("t2_busy", busy, 1);
        chk("t2_done_clr", done, 0);
        chk("t2_cnt_clr", wr_count, 0);
        strobe(16'd1);
        chk("t2_skip1", ram_we, 0);
        strobe(16'd2);
        chk("t2_skip2", ram_we, 0);
        strobe(16'd3);
        chk("t2_skip3", ram_we, 0);
        strobe(16'd4);
        chk("t2_we4", ram_we, 1);
        chk("t2_addr4", ram_addr, 0);
        chk("t2_data4", ram_data, 4);
        strobe(16'd5);
        chk("t2_addr5", ram_addr, 1);
        chk("t2_data5", ram_data, 5);
        chk("t2_done", done, 1);
        chk("t2_cnt", wr_count, 2);

        // 3: full buffer, back-to-back strobes, 4 extra
        arm(8'd0, 12'd0);
        bad = 0;
        nwr = 0;
        sample_valid = 1'b1;
        for (int i = 0; i < 4100; i++) begin
            sample_data = 16'(i + 16'h100);
            tick();
            if (ram_we) nwr++;
            if (i < 4096) begin
                if (ram_we !== 1'b1 || ram_addr !== 12'(i) ||
                    ram_data !== 16'(i + 16'h100))
                    bad++;
                if (i < 4095 && busy !== 1'b1) bad++;
                if (i == 4095 && done !== 1'b1) bad++;
            end else if (ram_we !== 1'b0) begin
                bad++;
            end
        end
        sample_valid = 1'b0;
        chk("t3_bad_cycles", bad, 0);
        chk("t3_writes", nwr, 4096);
        chk("t3_done", done, 1);
        chk("t3_cnt", wr_count, 4096);
        chk("t3_last_addr", ram_addr, 12'hfff);

        // 4: abort after 6 writes, idle strobe, then start+abort
        arm(8'd0, 12'd10);
        for (int i = 0; i < 6; i++) strobe(16'(16'ha0 + i));
        chk("t4_addr5", ram_addr, 5);
        abort = 1'b1;
        sample_valid = 1'b1;
        tick();
        abort = 1'b0;
        sample_valid = 1'b0;
        chk("t4_abort_we", ram_we, 0);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_done", done, 0);
        chk("t4_abort_cnt", wr_count, 6);
        strobe(16'hbeef);
        chk("t4_idle_we", ram_we, 0);
        abort = 1'b1;
        arm(8'd0, 12'd2);
        abort = 1'b0;
        chk("t4_rearm_busy", busy, 1);
        chk("t4_rearm_cnt", wr_count, 0);
        strobe(16'hc0);
        chk("t4_addr0", ram_addr, 0);
        strobe(16'hc1);
        chk("t4_addr1", ram_addr, 1);
        chk("t4_data1", ram_data, 16'hc1);
        chk("t4_done", done, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_done_abort", done, 1);

        // 5: start while busy is ignored
        arm(8'd0, 12'd3);
        strobe(16'hd0);
        arm(8'd5, 12'd8);
        chk("t5_busy", busy, 1);
        chk("t5_cnt1", wr_count, 1);
        strobe(16'hd1);
        chk("t5_we1", ram_we, 1);
        chk("t5_addr1", ram_addr, 1);
        strobe(16'hd2);
        chk("t5_addr2", ram_addr, 2);
        chk("t5_done", done, 1);
        chk("t5_cnt", wr_count, 3);
        strobe(16'hd3);
        chk("t5_extra_we", ram_we, 0);

        // 6: async reset with a write on the port
        arm(8'd0, 12'd5);
        strobe(16'he0);
        strobe(16'he1);
        chk("t6_we_pre", ram_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", ram_we, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_cnt", wr_count, 0);
        tick();
        rst_n = 1'b1;
        strobe(16'he2);
        chk("t6_post_we", ram_we, 0);
        chk("t6_post_busy", busy, 0);
        strobe(16'he3);
        chk("t6_post_we2", ram_we, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
